clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
Programmable clock-enable and divided-clock generator. It sits directly upstream of the blocking/non-blocking experiment stage and of the course datapath benches.
- Produces a one-cycle tick pulse every D enabled cycles, plus a divided square wave, so downstream registers advance at a controlled rate without gating clk.
- Divisor is reloadable at runtime through a shadow register that applies only at period boundaries.

Parameters:
CNT_W, 16, width of divisor and period counter
DEFAULT_DIV, 4, divisor after reset (values below 2 are clamped to 2)
TICKS_W, 32, width of the tick counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  count enable; low = freeze
clr  in  1  synchronous clear of period counter and tick_count
div_load  in  1  capture div_in into shadow register this edge
div_in  in  CNT_W  new divisor request
tick  out  1  one-cycle enable pulse, once per period
clk_div  out  1  divided square wave
div_cur  out  CNT_W  divisor currently in force
load_pending  out  1  shadow divisor waiting to be applied
tick_count  out  TICKS_W  number of ticks since reset or clr, wraps modulo 2^TICKS_W

Behaviour:
- Reset (rst_n=0 at an edge):
  - cnt=0, div_cur=max(DEFAULT_DIV,2).
  - shadow cleared; load_pending=0.
  - tick=0, clk_div=0, tick_count=0.
  - Reset mid-period aborts the period; no tick is emitted.
- Effective divisor: D = div_cur. Any divisor value 0 or 1 is clamped to 2 when applied. H = floor(D/2).
- Counting, at each edge with en=1 and clr=0:
  - cnt <= (cnt==D-1) ? 0 : cnt+1.
  - tick <= (cnt==D-1).
  - clk_div <= (cnt_next < H).
- Tick latency: with en held high from the first edge after reset release, tick is high for exactly one cycle after edge D. It then repeats every D cycles with no gaps or doubles.
- en=0: cnt and clk_div hold their values; tick <= 0; tick_count holds. Re-asserting en resumes mid-period; the stall is not counted.
- clr=1: cnt <= 0, tick <= 0, tick_count <= 0, clk_div <= 0. div_cur and the shadow are unaffected.
  - clr wins over a simultaneous wrap; that tick is suppressed.
- tick_count increments by 1 on each edge where tick is set to 1, and wraps to 0 after all-ones.
- Divisor reload:
  - div_load=1 captures div_in into the shadow and sets load_pending=1. A second load before apply overwrites the shadow (last wins).
  - Apply point: the wrap edge (en=1, cnt==D-1, clr=0), or any edge with en=0 or clr=1. At the apply point, div_cur <= clamp(shadow) and load_pending <= 0.
  - div_load on the same edge as an apply point: the previous shadow (if pending) is applied, and div_in becomes the new shadow with load_pending=1.
  - If nothing is pending, div_load on the stopped/clr edge captures only; the value applies at the next qualifying edge.
- No combinational path from inputs to outputs; all outputs are registers.

Decomposition:
- Shared header clk_tick_defs.vh: MIN_DIV=2 constant and the clamp macro/function, reused by later benches.
- One natural sub-module: clk_tick_period_cnt. It holds cnt, the wrap detect and H compare; the top holds the shadow/apply logic, tick and tick_count.

Test Plan:
- Reset then en=1, D=4, 20 cycles -> tick high after edges 4, 8, 12, 16, 20 only; clk_div pattern 1,0,0,1 repeating; tick_count=5.
- div_load with div_in=6 at edge 2 of a D=4 period -> load_pending=1 until edge 4; div_cur=6 from edge 4; next ticks after edges 10 and 16.
- div_in=0 and div_in=1 loaded while en=0 -> div_cur=2 on the next edge; with en=1, tick every 2nd cycle and clk_div toggles every cycle.
- D=5, drop en for 3 cycles at cnt=2 -> cnt and clk_div frozen, tick=0; the next tick is delayed by exactly 3 cycles; tick_count unchanged during the stall.
- clr asserted on the wrap edge (cnt=D-1) -> no tick, cnt=0, tick_count=0; div_cur unchanged.
- rst_n=0 at cnt=3 of D=8, with a load pending (shadow=10) -> all outputs at reset values next cycle, div_cur=4, load_pending=0.

Source files
------------

// File: rtl/clk_tick_gen_pkg.sv
// Shared constants and the divisor clamp for the tick generator and the benches built on it.
package clk_tick_gen_pkg;

  localparam int MIN_DIV = 2;
  localparam int CLAMP_W = 32;

  typedef logic [CLAMP_W-1:0] div_word_t;

  // Divisors of 0 or 1 would give a degenerate period, so they become MIN_DIV.
  function automatic div_word_t clamp_div(input div_word_t v);
    return (v < div_word_t'(MIN_DIV)) ? div_word_t'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_tick_period_cnt.sv
// Period counter: walks cnt through 0..div-1, flags the wrap and drives the divided square wave.
module clk_tick_period_cnt
  import clk_tick_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             clk_div
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] half;

  assign half = div >> 1;

  // >= rather than == so a divisor shrunk below cnt while stalled still wraps promptly.
  assign wrap     = (cnt >= div - CNT_W'(1));
  assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_next;
      clk_div <= (cnt_next < half);
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// Programmable clock-enable generator: one-cycle tick every div_cur enabled cycles, divided
// square wave, tick counter, and a shadowed divisor that only changes at period boundaries.
module clk_tick_gen
  import clk_tick_gen_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int TICKS_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_in,
  output logic               tick,
  output logic               clk_div,
  output logic [CNT_W-1:0]   div_cur,
  output logic               load_pending,
  output logic [TICKS_W-1:0] tick_count
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(div_word_t'(DEFAULT_DIV)));

  logic [CNT_W-1:0] shadow;
  logic             wrap;
  logic             wrap_edge;
  logic             apply;

  clk_tick_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .div     (div_cur),
    .wrap    (wrap),
    .clk_div (clk_div)
  );

  // A new divisor may only take effect where no period is in flight: the wrap, a stall or a clear.
  assign wrap_edge = en & ~clr & wrap;
  assign apply     = wrap_edge | ~en | clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cur      <= RESET_DIV;
      shadow       <= '0;
      load_pending <= 1'b0;
    end else begin
      if (apply && load_pending) begin
        div_cur      <= CNT_W'(clamp_div(div_word_t'(shadow)));
        load_pending <= 1'b0;
      end
      // A load on an apply edge queues behind the value being applied now.
      if (div_load) begin
        shadow       <= div_in;
        load_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else if (clr) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= wrap_edge;
      if (wrap_edge) begin
        tick_count <= tick_count + TICKS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen: hand-computed checks per scenario plus a cycle model compared every cycle.
module tb_clk_tick_gen;

  localparam int CNT_W   = 16;
  localparam int TICKS_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clr;
  logic               div_load;
  logic [CNT_W-1:0]   div_in;
  logic               tick;
  logic               clk_div;
  logic [CNT_W-1:0]   div_cur;
  logic               load_pending;
  logic [TICKS_W-1:0] tick_count;

  int n_vec  = 0;
  int n_miss = 0;

  clk_tick_gen #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4),
    .TICKS_W     (TICKS_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (clr),
    .div_load     (div_load),
    .div_in       (div_in),
    .tick         (tick),
    .clk_div      (clk_div),
    .div_cur      (div_cur),
    .load_pending (load_pending),
    .tick_count   (tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: position within the period, divisor in force, pending request, tick tally.
  int          m_pos;
  int          m_div;
  int          m_req;
  bit          m_req_valid;
  bit          m_tick;
  bit          m_sq;
  logic [31:0] m_tally;
  bit          m_valid = 0;
  bit          m_end;
  bit          m_boundary;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_div = 4; m_req = 0; m_req_valid = 0;
      m_tick = 0; m_sq = 0; m_tally = 0; m_valid = 1;
    end else begin
      m_end      = en && !clr && (m_pos == m_div - 1);
      m_boundary = m_end || !en || clr;
      if (clr) begin
        m_pos = 0; m_tick = 0; m_tally = 0; m_sq = 0;
      end else if (en) begin
        m_pos  = (m_pos + 1) % m_div;
        m_tick = m_end;
        m_sq   = (m_pos < m_div / 2);
        if (m_end) m_tally = m_tally + 1;
      end else begin
        m_tick = 0;
      end
      if (m_boundary && m_req_valid) begin
        m_div       = (m_req < 2) ? 2 : m_req;
        m_req_valid = 0;
      end
      if (div_load) begin
        m_req       = int'(div_in);
        m_req_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tick",         64'(tick),         64'(m_tick));
      chk("model_clk_div",      64'(clk_div),      64'(m_sq));
      chk("model_div_cur",      64'(div_cur),      64'(m_div));
      chk("model_load_pending", 64'(load_pending), 64'(m_req_valid));
      chk("model_tick_count",   64'(tick_count),   64'(m_tally));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit sq_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [TICKS_W-1:0] saved_count;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = '0;
    step();
    step();
    chk("rst_tick",    64'(tick),         64'd0);
    chk("rst_clk_div", 64'(clk_div),      64'd0);
    chk("rst_div_cur", 64'(div_cur),      64'd4);
    chk("rst_pending", 64'(load_pending), 64'd0);
    chk("rst_count",   64'(tick_count),   64'd0);

    // D=4 free run: ticks after edges 4,8,..,20; square wave 1,0,0,1.
    rst_n = 1'b1; en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk("d4_tick",    64'(tick),    64'(e % 4 == 0));
      chk("d4_clk_div", 64'(clk_div), 64'(sq_pat[(e - 1) % 4]));
    end
    chk("d4_count", 64'(tick_count), 64'd5);

    // Load 6 on the second edge of a period; it applies at the wrap edge 24.
    for (int e = 21; e <= 36; e++) begin
      div_load = (e == 22);
      div_in   = 16'd6;
      step();
      chk("ld6_tick",    64'(tick),         64'(e == 24 || e == 30 || e == 36));
      chk("ld6_pending", 64'(load_pending), 64'(e == 22 || e == 23));
      chk("ld6_div_cur", 64'(div_cur),      (e >= 24) ? 64'd6 : 64'd4);
    end
    div_load = 1'b0;
    chk("ld6_count", 64'(tick_count), 64'd8);

    // Divisors 0 and 1 loaded while stopped clamp to 2.
    en = 1'b0; div_load = 1'b1; div_in = 16'd0;
    step();
    chk("clamp_pend0",  64'(load_pending), 64'd1);
    chk("clamp_div0",   64'(div_cur),      64'd6);
    div_in = 16'd1;
    step();
    chk("clamp_div0a",  64'(div_cur),      64'd2);
    chk("clamp_pend1",  64'(load_pending), 64'd1);
    div_load = 1'b0;
    step();
    chk("clamp_div1a",  64'(div_cur),      64'd2);
    chk("clamp_pend1a", 64'(load_pending), 64'd0);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("d2_tick",    64'(tick),    64'(k % 2 == 0));
      chk("d2_clk_div", 64'(clk_div), 64'(k % 2 == 0));
    end
    chk("d2_count", 64'(tick_count), 64'd12);

    // D=5 with a 3-cycle stall at cnt=2: tick slides from edge 5 to edge 8.
    en = 1'b0; div_load = 1'b1; div_in = 16'd5;
    step();
    div_load = 1'b0;
    step();
    chk("d5_div_cur", 64'(div_cur), 64'd5);
    saved_count = tick_count;
    for (int k = 1; k <= 8; k++) begin
      en = !(k >= 3 && k <= 5);
      step();
      chk("stall_tick", 64'(tick), 64'(k == 8));
      if (k >= 3 && k <= 5) begin
        chk("stall_clk_div", 64'(clk_div),    64'd0);
        chk("stall_count",   64'(tick_count), 64'(saved_count));
      end
    end
    en = 1'b1;
    chk("stall_count_after", 64'(tick_count), 64'd13);

    // clr on the wrap edge suppresses the tick and zeroes the tally.
    for (int k = 1; k <= 4; k++) step();
    clr = 1'b1;
    step();
    chk("clr_tick",    64'(tick),       64'd0);
    chk("clr_count",   64'(tick_count), 64'd0);
    chk("clr_clk_div", 64'(clk_div),    64'd0);
    chk("clr_div_cur", 64'(div_cur),    64'd5);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("post_clr_tick", 64'(tick), 64'(k == 5));
    end
    chk("post_clr_count", 64'(tick_count), 64'd1);

    // Reset at cnt=3 of D=8 with shadow=10 pending.
    en = 1'b0; div_load = 1'b1; div_in = 16'd8;
    step();
    div_load = 1'b0;
    step();
    chk("d8_div_cur", 64'(div_cur), 64'd8);
    en = 1'b1; div_load = 1'b1; div_in = 16'd10;
    step();
    div_load = 1'b0;
    step();
    step();
    chk("d8_pending", 64'(load_pending), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tick",    64'(tick),         64'd0);
    chk("mid_rst_clk_div", 64'(clk_div),      64'd0);
    chk("mid_rst_div_cur", 64'(div_cur),      64'd4);
    chk("mid_rst_pending", 64'(load_pending), 64'd0);
    chk("mid_rst_count",   64'(tick_count),   64'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("after_rst_tick", 64'(tick), 64'(e % 4 == 0));
    end
    chk("after_rst_count", 64'(tick_count), 64'd2);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
